// File: rtl/uart_tx_ctrl.sv
// Control stage feeding the UART TX 10-bit shift register: byte handshake, load/shift pulses, bit timing.
// Optional one-entry holding buffer for back-to-back frames is enabled with `define UART_TX_BUFFER_EN.
module uart_tx_ctrl #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       load,
   output logic [7:0] load_data,
   output logic       shift_en,
   output logic       busy,
   output logic       tx_done
);

   localparam int BAUD_DIV   = CLK_FREQ / BAUD;
   localparam int FRAME_BITS = 10;
   localparam int CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
   localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

   if (BAUD_DIV < 2) begin : g_bad_div
      $error("uart_tx_ctrl: CLK_FREQ/BAUD must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, LOAD_TX, SEND_TX} state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       data_reg;
   logic             accept;

`ifdef UART_TX_BUFFER_EN
   logic [7:0] buf_data;
   logic       buf_valid;
   logic       frame_end;

   assign tx_ready  = !buf_valid;
   assign frame_end = (state == SEND_TX) && (baud_cnt == CNT_LAST) && (bit_cnt == BIT_LAST);
`else
   assign tx_ready = (state == IDLE);
`endif

   assign accept    = tx_start && tx_ready;
   assign busy      = (state != IDLE);
   assign load_data = data_reg;

   // Pulses are registered one cycle ahead so they line up with the counter values they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         data_reg <= 8'h00;
         load     <= 1'b0;
         shift_en <= 1'b0;
         tx_done  <= 1'b0;
`ifdef UART_TX_BUFFER_EN
         buf_valid <= 1'b0;
`endif
      end else begin
         load     <= 1'b0;
         shift_en <= 1'b0;
         tx_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  data_reg <= tx_data;
                  load     <= 1'b1;
                  state    <= LOAD_TX;
               end
            end
            LOAD_TX: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               state    <= SEND_TX;
            end
            SEND_TX: begin
               shift_en <= (baud_cnt == CNT_PRE);
               tx_done  <= (baud_cnt == CNT_PRE) && (bit_cnt == BIT_LAST);
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
`ifdef UART_TX_BUFFER_EN
                     // Chain straight into the next frame: buffered byte first, else a fresh offer.
                     if (buf_valid) begin
                        data_reg  <= buf_data;
                        buf_valid <= 1'b0;
                        load      <= 1'b1;
                        state     <= LOAD_TX;
                     end else if (tx_start) begin
                        data_reg <= tx_data;
                        load     <= 1'b1;
                        state    <= LOAD_TX;
                     end
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef UART_TX_BUFFER_EN
         if (accept && (state != IDLE) && !frame_end) begin
            buf_data  <= tx_data;
            buf_valid <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table of frame vectors, randomized frames and corner sequences.
// Event times are checked against the frame timing rules; the serial line is rebuilt from load/shift pulses.
module tb_uart_tx_ctrl;

`ifdef UART_TX_BUFFER_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       sel;

   logic       start_a, ready_a, load_a, shift_a, busy_a, done_a;
   logic       start_b, ready_b, load_b, shift_b, busy_b, done_b;
   logic [7:0] ld_a, ld_b;

   assign start_a = tx_start && !sel;
   assign start_b = tx_start && sel;

   uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut_a (
      .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(tx_data), .tx_ready(ready_a),
      .load(load_a), .load_data(ld_a), .shift_en(shift_a), .busy(busy_a), .tx_done(done_a)
   );

   uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD(500_000)) dut_b (
      .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(tx_data), .tx_ready(ready_b),
      .load(load_b), .load_data(ld_b), .shift_en(shift_b), .busy(busy_b), .tx_done(done_b)
   );

   logic       m_load, m_shift, m_done, m_busy, m_ready;
   logic [7:0] m_ld;
   assign m_load  = sel ? load_b  : load_a;
   assign m_shift = sel ? shift_b : shift_a;
   assign m_done  = sel ? done_b  : done_a;
   assign m_busy  = sel ? busy_b  : busy_a;
   assign m_ready = sel ? ready_b : ready_a;
   assign m_ld    = sel ? ld_b    : ld_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   int   load_c[$];
   int   shift_c[$];
   int   done_c[$];
   int   fall_c[$];
   logic [7:0] load_d[$];
   logic line_q[$];
   logic [9:0] sr = '1;
   logic prev_busy = 1'b0;
   int   overlap = 0;

   // Event monitor; also a model of the downstream shift register to recover the serial line.
   always @(negedge clk) begin
      if (m_load) begin
         load_c.push_back(cyc);
         load_d.push_back(m_ld);
         line_q.push_back(1'b0);
      end
      if (m_shift) begin
         shift_c.push_back(cyc);
         line_q.push_back(sr[1]);
      end
      if (m_done) done_c.push_back(cyc);
      if (prev_busy && !m_busy) fall_c.push_back(cyc);
      if (m_load && m_shift) overlap <= overlap + 1;
      prev_busy <= m_busy;
      if (!rst_n) sr <= '1;
      else if (m_load) sr <= {1'b1, m_ld, 1'b0};
      else if (m_shift) sr <= {1'b1, sr[9:1]};
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      load_c.delete(); load_d.delete(); shift_c.delete();
      done_c.delete(); fall_c.delete(); line_q.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // One frame: offer d, optionally poke tx_start=1/tx_data=FF at offsets r1/r2, then check event timing.
   task automatic frame(input string nm, input logic [7:0] d, input int div, input int r1, input int r2,
                        input int e_load, input int e_done, input int e_fall);
      int t, n, bad;
      logic [10:0] exp_line, act_line;
      clear_mon();
      step();
      n = 0;
      while (!m_ready && n < 1000) begin
         step();
         n++;
      end
      check({nm, " ready"}, int'(m_ready), 1);
      t = cyc;
      tx_start = 1'b1;
      tx_data  = d;
      for (int i = 1; i <= 10 * div + 12; i++) begin
         step();
         tx_start = (i == r1) || (i == r2);
         tx_data  = tx_start ? 8'hFF : 8'($urandom);
      end
      tx_start = 1'b0;
      @(negedge clk);
      check({nm, " load count"}, load_c.size(), 1);
      if (load_c.size() > 0) begin
         check({nm, " load cycle"}, load_c[0] - t, e_load);
         check({nm, " load data"}, int'(load_d[0]), int'(d));
      end
      check({nm, " shift count"}, shift_c.size(), 10);
      bad = 0;
      foreach (shift_c[k]) if (shift_c[k] - t != e_load + (k + 1) * div) bad++;
      check({nm, " shift spacing"}, bad, 0);
      check({nm, " done count"}, done_c.size(), 1);
      if (done_c.size() > 0) check({nm, " done cycle"}, done_c[0] - t, e_done);
      check({nm, " busy fall"}, (fall_c.size() > 0) ? fall_c[0] - t : -1, e_fall);
      exp_line = '0;
      exp_line = {exp_line[9:0], 1'b0};
      for (int i = 0; i < 8; i++) exp_line = {exp_line[9:0], d[i]};
      exp_line = {exp_line[9:0], 1'b1};
      exp_line = {exp_line[9:0], 1'b1};
      act_line = '0;
      foreach (line_q[k]) act_line = {act_line[9:0], line_q[k]};
      check({nm, " line bits"}, int'(act_line), int'(exp_line));
   endtask

   typedef struct {
      logic [7:0] data;
      int r1;
      int r2;
      int e_load;
      int e_done;
      int e_fall;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 5000", cyc);
      $fatal(1);
   end

   initial begin
      int t, n, bad;
      logic [7:0] d;

      tbl[0] = '{data: 8'hA5, r1: -1, r2: -1,  e_load: 1, e_done: 101, e_fall: 102};
      tbl[1] = '{data: 8'h3C, r1: 5,  r2: 101, e_load: 1, e_done: 101, e_fall: 102};
      tbl[2] = '{data: 8'h81, r1: 1,  r2: 100, e_load: 1, e_done: 101, e_fall: 102};
      tbl[3] = '{data: 8'h00, r1: -1, r2: -1,  e_load: 1, e_done: 101, e_fall: 102};

      rst_n = 1'b0;
      tx_start = 1'b0;
      tx_data = 8'h00;
      sel = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset tx_ready", int'(ready_a), 1);
      check("reset busy", int'(busy_a), 0);
      check("reset load", int'(load_a), 0);
      check("reset shift_en", int'(shift_a), 0);
      check("reset tx_done", int'(done_a), 0);
      check("reset load_data", int'(ld_a), 0);
      step();
      rst_n = 1'b1;
      clear_mon();
      repeat (20) step();
      @(negedge clk);
      check("idle pulses", load_c.size() + shift_c.size() + done_c.size(), 0);

      // Vector table at BAUD_DIV=10; busy-time offers only make sense without the buffer.
      foreach (tbl[i]) begin
         if (BUF_EN && (tbl[i].r1 >= 0 || tbl[i].r2 >= 0)) continue;
         frame($sformatf("vec%0d", i), tbl[i].data, 10, tbl[i].r1, tbl[i].r2,
               tbl[i].e_load, tbl[i].e_done, tbl[i].e_fall);
      end

      // Randomized frames with random idle gaps and random ignored offers.
      for (int r = 0; r < 8; r++) begin
         d = 8'($urandom);
         repeat ($urandom_range(0, 5)) step();
         frame($sformatf("rand%0d", r), d, 10,
               BUF_EN ? -1 : int'($urandom_range(1, 101)),
               BUF_EN ? -1 : int'($urandom_range(1, 101)),
               1, 1 + 10 * 10, 2 + 10 * 10);
      end

      // Minimum divider.
      sel = 1'b1;
      frame("mindiv", 8'h00, 2, -1, -1, 1, 21, 22);
      sel = 1'b0;

      // Reset in the middle of a frame.
      clear_mon();
      step();
      t = cyc;
      tx_start = 1'b1;
      tx_data = 8'h55;
      for (int i = 1; i <= 40; i++) begin
         step();
         tx_start = 1'b0;
         if (i == 40) rst_n = 1'b0;
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst tx_ready", int'(ready_a), 1);
      check("midrst busy", int'(busy_a), 0);
      check("midrst load", int'(load_a), 0);
      repeat (30) step();
      @(negedge clk);
      bad = 0;
      foreach (shift_c[k]) if (shift_c[k] > t + 40) bad++;
      check("midrst late shifts", bad, 0);
      check("midrst early shifts", shift_c.size(), 3);
      check("midrst line high", int'(sr[0]), 1);
      check("midrst loads", load_c.size(), 1);

`ifdef UART_TX_BUFFER_EN
      // Buffered back-to-back frames.
      clear_mon();
      step();
      t = cyc;
      tx_start = 1'b1;
      tx_data = 8'h11;
      bad = 0;
      for (int i = 1; i <= 320; i++) begin
         step();
         if (i >= 4 && i <= 101 && m_ready) bad++;
         if (i == 102) check("buf ready after done", int'(m_ready), 1);
         if (i == 110) check("buf ready frame2", int'(m_ready), 1);
         if (i == 111) check("buf ready after third", int'(m_ready), 0);
         tx_start = (i == 3) || (i == 110);
         tx_data = (i == 3) ? 8'h22 : (i == 110) ? 8'h33 : 8'($urandom);
      end
      tx_start = 1'b0;
      @(negedge clk);
      check("buf ready held low", bad, 0);
      check("buf load count", load_c.size(), 3);
      if (load_c.size() == 3) begin
         check("buf load1 cycle", load_c[0] - t, 1);
         check("buf load2 cycle", load_c[1] - t, 102);
         check("buf load3 cycle", load_c[2] - t, 203);
         check("buf load2 data", int'(load_d[1]), 8'h22);
         check("buf load3 data", int'(load_d[2]), 8'h33);
      end
      check("buf done count", done_c.size(), 3);
      if (done_c.size() == 3) check("buf done3 cycle", done_c[2] - t, 303);
`endif

      check("load shift overlap", overlap, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Control stage that sits directly upstream of the UART TX 10-bit shift register (start + 8 data + stop, LSB first, 115200 baud).
- Accepts a byte over a ready/valid handshake.
- Drives the shift register's load, shift_en and parallel data inputs.
- Runs the bps counter only while a frame is being sent.
- Signals busy and frame completion to the host logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line bit rate in bits/s
BAUD_DIV, CLK_FREQ/BAUD (434 at defaults), clocks per bit (integer division, truncated); must be >= 2
FRAME_BITS, 10, shifts per frame (start + 8 data + stop); fixed, not for override

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
tx_start  input  1  host valid: byte on tx_data is offered this cycle
tx_data  input  8  byte to transmit, LSB sent first
tx_ready  output  1  controller can accept a byte this cycle
load  output  1  one-cycle pulse to shift register load input
load_data  output  8  byte presented to shift register d input (held data register)
shift_en  output  1  one-cycle pulse to shift register shift_en input, once per bit period
busy  output  1  high from accept until frame end (state != IDLE)
tx_done  output  1  one-cycle pulse when the stop bit period completes

Behaviour:
- Reset and interface
  - Reset rst_n, synchronous, active-low; clock clk.
  - Reset values: state IDLE, baud_cnt 0, bit_cnt 0, data_reg 8'h00, load 0, shift_en 0, tx_done 0, busy 0, tx_ready 1.
- Handshake
  - A byte is accepted in cycle T when tx_start && tx_ready.
  - tx_data is captured into data_reg at the end of T.
  - tx_data is not sampled in any other cycle.
- FSM
  - IDLE: tx_ready=1. On accept, go to LOAD_TX.
  - LOAD_TX (cycle T+1): exactly one cycle. load=1, load_data=data_reg. Clear baud_cnt and bit_cnt. Go to SEND_TX. The line shows the start bit from T+2.
  - SEND_TX:
    - baud_cnt increments 0..BAUD_DIV-1 and wraps to 0.
    - shift_en=1 exactly when baud_cnt==BAUD_DIV-1; bit_cnt increments on that cycle.
    - The k-th shift_en occurs at cycle T+1+k*BAUD_DIV, for k=1..10.
    - On the 10th shift_en (bit_cnt==9 at that edge), tx_done=1 in the same cycle and the next state is IDLE. busy falls at T+2+10*BAUD_DIV.
- Outputs
  - load, shift_en and tx_done are decoded from registered state and counters only; no combinational path from any input.
  - load and shift_en are never high in the same cycle.
- Busy conditions
  - tx_ready=0 in LOAD_TX and SEND_TX.
  - tx_start while busy is ignored and tx_data is not captured.
  - tx_start in the tx_done cycle is also ignored, because the state is still SEND_TX.
- Reset mid-frame: return to IDLE on the next edge with all counters cleared and no further load or shift_en pulses. The shift register resets to all ones, so the line idles high.
- Widths
  - baud_cnt is $clog2(BAUD_DIV) bits.
  - bit_cnt is 4 bits and never exceeds 9.
  - data_reg holds its value across IDLE until the next accept.

Optional Feature:
UART_TX_BUFFER_EN
- Defined: adds a one-entry holding buffer (buf_data[7:0], buf_valid).
  - tx_ready = !buf_valid in every state.
  - An accept outside IDLE writes the buffer and sets buf_valid.
  - In the tx_done cycle, if buf_valid: next state is LOAD_TX with data_reg <= buf_data and buf_valid cleared.
  - In the tx_done cycle, if the buffer is empty and tx_start is high: tx_data is captured directly into data_reg and the next state is LOAD_TX.
  - Back-to-back frames therefore have exactly one extra high clock between the stop bit and the next start bit.
  - Reset clears buf_valid.
- Undefined: the buffer logic is absent and tx_ready = (state==IDLE) exactly as described above.

Test Plan:
- Test settings: CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10).
- Reset: hold rst_n=0 for 3 cycles → tx_ready=1, busy=0, load=0, shift_en=0, tx_done=0; then release and idle 20 cycles → no pulses.
- Single frame: tx_start with tx_data=8'hA5 at cycle T → load at T+1 with load_data=8'hA5; shift_en at T+11, T+21, …, T+101 (10 pulses); tx_done at T+101; busy low from T+102. Serial line via shift register = 0,1,0,1,0,0,1,0,1,1.
- Busy reject: accept 8'h3C, then tx_start with 8'hFF at T+5 and in the tx_done cycle → ignored; load_data stays 8'h3C; only one frame sent.
- Mid-frame reset: accept 8'h55, assert rst_n=0 for 1 cycle at T+40 → IDLE next edge, no shift_en afterwards, tx_ready=1, line high.
- Min divider: BAUD_DIV=2, send 8'h00 → 10 shift_en pulses exactly 2 cycles apart; tx_done at T+21.
- UART_TX_BUFFER_EN: accept 8'h11, then 8'h22 at T+3 → tx_ready=0 until the tx_done of frame 1; second load at T+102 with load_data=8'h22; third tx_start during frame 2 is accepted.
